// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register: branch funct3 encodings
// and the width of one packed pipe entry.
package ex_mem_pipe_reg_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  // memToReg, regWrite, memRead, memWrite
  localparam int ENTRY_CTRL_BITS = 4;

  // Entry = control bits + ALU/link value + store data + destination register.
  function automatic int pipe_entry_width(input int word_bits, input int reg_bits);
    return ENTRY_CTRL_BITS + 2 * word_bits + reg_bits;
  endfunction

endpackage

// File: rtl/ex_branch_cmp.sv
// Combinational branch condition: evaluates the funct3 compare mode on the
// forwarded operands. Undefined funct3 codes never take.
module ex_branch_cmp
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic [2:0]               i_funct3,
  input  logic [WORD_BITWIDTH-1:0] i_a,
  input  logic [WORD_BITWIDTH-1:0] i_b,
  output logic                     o_cond
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_a == i_b);
  assign w_lt_s = ($signed(i_a) < $signed(i_b));
  assign w_lt_u = (i_a < i_b);

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      BR_BEQ:  o_cond = w_eq;
      BR_BNE:  o_cond = ~w_eq;
      BR_BLT:  o_cond = w_lt_s;
      BR_BGE:  o_cond = ~w_lt_s;
      BR_BLTU: o_cond = w_lt_u;
      BR_BGEU: o_cond = ~w_lt_u;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid buffer,
// flush, and in-stage branch/jump resolution producing a one-cycle PCSrc pulse.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int WORD_BITWIDTH    = 32,
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int FLUSH_ON_TAKEN   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid,
  output logic                        ex_ready,
  input  logic                        flush,
  input  logic                        memToReg,
  input  logic                        regWrite,
  input  logic                        memRead,
  input  logic                        memWrite,
  input  logic                        branch,
  input  logic                        jump,
  input  logic                        jalr,
  input  logic [2:0]                  br_funct3,
  input  logic [WORD_BITWIDTH-1:0]    cmp_a,
  input  logic [WORD_BITWIDTH-1:0]    cmp_b,
  input  logic [WORD_BITWIDTH-1:0]    ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    readData2,
  input  logic [REG_NUM_BITWIDTH-1:0] regToWrite,
  input  logic [WORD_BITWIDTH-1:0]    ex_pc,
  input  logic [WORD_BITWIDTH-1:0]    ex_imm,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic                        mem_memToReg,
  output logic                        mem_memRead,
  output logic                        mem_memWrite,
  output logic                        mem_regWrite,
  output logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
  output logic [WORD_BITWIDTH-1:0]    mem_readData2,
  output logic [REG_NUM_BITWIDTH-1:0] mem_regToWrite,
  output logic                        PCSrc,
  output logic [WORD_BITWIDTH-1:0]    branch_pc
);

  localparam int ENTRY_W = pipe_entry_width(WORD_BITWIDTH, REG_NUM_BITWIDTH);

  typedef struct packed {
    logic                        mem_to_reg;
    logic                        reg_write;
    logic                        mem_read;
    logic                        mem_write;
    logic [WORD_BITWIDTH-1:0]    alu_result;
    logic [WORD_BITWIDTH-1:0]    store_data;
    logic [REG_NUM_BITWIDTH-1:0] rd;
  } entry_t;

  logic [ENTRY_W-1:0]       r_out;
  logic [ENTRY_W-1:0]       r_skid;
  logic                     r_mem_valid;
  logic                     r_skid_full;
  logic                     r_ex_ready;
  logic                     r_pcsrc;
  logic [WORD_BITWIDTH-1:0] r_branch_pc;
  logic                     r_drop_next;

  logic                     w_cond;
  logic                     w_is_jump;
  logic                     w_taken;
  logic                     w_accept;
  logic                     w_advance;
  logic                     w_taken_accept;
  logic [WORD_BITWIDTH-1:0] w_target;
  logic [WORD_BITWIDTH-1:0] w_link;
  entry_t                   w_in_s;
  logic [ENTRY_W-1:0]       w_in;
  entry_t                   w_out_s;

  ex_branch_cmp #(
    .WORD_BITWIDTH(WORD_BITWIDTH)
  ) u_branch_cmp (
    .i_funct3(br_funct3),
    .i_a     (cmp_a),
    .i_b     (cmp_b),
    .o_cond  (w_cond)
  );

  assign w_is_jump = jump | jalr;
  assign w_taken   = w_is_jump | (branch & w_cond);
  assign w_target  = jalr ? (ALUresult & ~WORD_BITWIDTH'(1)) : (ex_pc + ex_imm);
  assign w_link    = w_is_jump ? (ex_pc + WORD_BITWIDTH'(4)) : ALUresult;

  // The cycle after a taken accept carries a wrong-path instruction; it is ignored.
  assign w_accept       = ex_valid & r_ex_ready & ~flush & ~r_drop_next;
  assign w_advance      = ~r_mem_valid | mem_ready;
  assign w_taken_accept = w_accept & w_taken;

  always_comb begin
    w_in_s            = '0;
    w_in_s.mem_to_reg = memToReg;
    w_in_s.reg_write  = regWrite;
    w_in_s.mem_read   = memRead;
    w_in_s.mem_write  = memWrite;
    w_in_s.alu_result = w_link;
    w_in_s.store_data = readData2;
    w_in_s.rd         = regToWrite;
  end

  assign w_in    = w_in_s;
  assign w_out_s = entry_t'(r_out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_mem_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_ex_ready  <= 1'b1;
      r_pcsrc     <= 1'b0;
      r_branch_pc <= '0;
      r_drop_next <= 1'b0;
    end else if (flush) begin
      r_mem_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_ex_ready  <= 1'b1;
      r_pcsrc     <= 1'b0;
      r_drop_next <= 1'b0;
    end else begin
      r_pcsrc     <= w_taken_accept;
      r_drop_next <= (FLUSH_ON_TAKEN != 0) && w_taken_accept;
      if (w_taken_accept) begin
        r_branch_pc <= w_target;
      end

      if (w_advance) begin
        if (r_skid_full) begin
          // Skid drains first; a simultaneous accept refills it to keep order.
          r_out       <= r_skid;
          r_mem_valid <= 1'b1;
          r_skid_full <= w_accept;
          r_ex_ready  <= ~w_accept;
          if (w_accept) begin
            r_skid <= w_in;
          end
        end else begin
          r_mem_valid <= w_accept;
          r_ex_ready  <= 1'b1;
          if (w_accept) begin
            r_out <= w_in;
          end
        end
      end else if (w_accept) begin
        r_skid      <= w_in;
        r_skid_full <= 1'b1;
        r_ex_ready  <= 1'b0;
      end
    end
  end

  assign ex_ready       = r_ex_ready;
  assign mem_valid      = r_mem_valid;
  assign mem_memToReg   = w_out_s.mem_to_reg & r_mem_valid;
  assign mem_regWrite   = w_out_s.reg_write & r_mem_valid;
  assign mem_memRead    = w_out_s.mem_read & r_mem_valid;
  assign mem_memWrite   = w_out_s.mem_write & r_mem_valid;
  assign mem_ALUresult  = w_out_s.alu_result;
  assign mem_readData2  = w_out_s.store_data;
  assign mem_regToWrite = w_out_s.rd;
  assign PCSrc          = r_pcsrc;
  assign branch_pc      = r_branch_pc;

endmodule
